// File: rtl/wash_job_scheduler.sv
// wash_job_scheduler
//   Buffers wash jobs in a small FIFO and runs them one at a time on a single
//   washing machine. Each launch holds wm_start high for LAUNCH_CYC cycles. The
//   job is retired on the rising edge of the machine's done. While a job runs,
//   the user pause level is forwarded to the machine. A watchdog counts
//   unpaused run cycles and latches a sticky fault if the machine never
//   finishes.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   job_valid       job offered; accepted when job_ready is also high
//   job_double/dry  mode bits carried with the job
//   job_ready       FIFO has room, no flush in progress, no fault
//   flush           drop every queued (not yet launched) job
//   pause_req       user pause level, forwarded only while running
//   wm_start        launch pulse to the machine
//   wm_double_wash  mode to the machine, held from launch to retirement
//   wm_dry_wash     mode to the machine, held from launch to retirement
//   wm_time_pause   registered copy of pause_req while running
//   wm_done         machine done level (stays high until the next start)
//   busy            a job is launched and not yet retired
//   queue_level     FIFO occupancy, 0..DEPTH
//   jobs_done       completed-job count, saturating at 255
//   fault           watchdog expired; cleared only by rst
module wash_job_scheduler #(
    parameter int DEPTH       = 4,
    parameter int LAUNCH_CYC  = 2,
    parameter int TIMEOUT_CYC = 400,
    parameter int TMR_W       = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   job_valid,
    input  logic                   job_double,
    input  logic                   job_dry,
    output logic                   job_ready,
    input  logic                   flush,
    input  logic                   pause_req,
    output logic                   wm_start,
    output logic                   wm_double_wash,
    output logic                   wm_dry_wash,
    output logic                   wm_time_pause,
    input  logic                   wm_done,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] queue_level,
    output logic [7:0]             jobs_done,
    output logic                   fault
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(LAUNCH_CYC + 1);
    localparam logic [AW:0]      FULL_LEVEL  = (AW + 1)'(DEPTH);
    localparam logic [LW-1:0]    LAUNCH_LAST = LW'(LAUNCH_CYC);
    localparam logic [TMR_W-1:0] TIMER_LAST  = TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_FAULT} state_t;

    typedef struct packed {
        logic dbl;
        logic dry;
    } job_t;

    state_t           state;
    job_t             mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    launch_cnt;
    logic [TMR_W-1:0] timer;
    logic             wm_done_q;
    logic             push;
    logic             pop;
    logic             done_rise;

    // Readiness looks at the current level only, so a full FIFO never takes a
    // push on the same edge that pops it.
    assign job_ready = (queue_level < FULL_LEVEL) & ~flush & ~fault;
    assign push      = job_valid & job_ready;
    // Only an idle, non-faulted scheduler pops; flush suppresses the pop too.
    assign pop       = (state == S_IDLE) & (queue_level != '0) & ~flush;
    assign done_rise = wm_done & ~wm_done_q;

    // NOTE: job payload storage carries no reset; pointers and level define
    // which entries are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {job_double, job_dry};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            queue_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   queue_level <= queue_level + (AW + 1)'(1);
                2'b01:   queue_level <= queue_level - (AW + 1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            wm_done_q      <= 1'b0;
            wm_start       <= 1'b0;
            wm_double_wash <= 1'b0;
            wm_dry_wash    <= 1'b0;
            wm_time_pause  <= 1'b0;
            busy           <= 1'b0;
            fault          <= 1'b0;
            jobs_done      <= '0;
            launch_cnt     <= '0;
            timer          <= '0;
        end else begin
            wm_done_q <= wm_done;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        {wm_double_wash, wm_dry_wash} <= mem[rd_ptr];
                        wm_start   <= 1'b1;
                        busy       <= 1'b1;
                        launch_cnt <= LW'(1);
                        state      <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    // launch_cnt counts the start-high cycles already issued.
                    if (launch_cnt == LAUNCH_LAST) begin
                        wm_start <= 1'b0;
                        timer    <= '0;
                        state    <= S_RUN;
                    end else begin
                        launch_cnt <= launch_cnt + LW'(1);
                    end
                end
                S_RUN: begin
                    // Retirement is checked first so a done on the final
                    // watchdog cycle still completes the job.
                    if (done_rise) begin
                        if (jobs_done != 8'hFF) jobs_done <= jobs_done + 8'd1;
                        busy           <= 1'b0;
                        wm_double_wash <= 1'b0;
                        wm_dry_wash    <= 1'b0;
                        wm_time_pause  <= 1'b0;
                        state          <= S_IDLE;
                    end else if (!pause_req && timer == TIMER_LAST) begin
                        fault          <= 1'b1;
                        busy           <= 1'b0;
                        wm_double_wash <= 1'b0;
                        wm_dry_wash    <= 1'b0;
                        wm_time_pause  <= 1'b0;
                        state          <= S_FAULT;
                    end else begin
                        wm_time_pause <= pause_req;
                        if (!pause_req) timer <= timer + TMR_W'(1);
                    end
                end
                S_FAULT: ;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wash_job_scheduler.sv
// tb_wash_job_scheduler
//   Stimulus pushes every accepted job, with its modes and the machine's
//   completion time, into an expected-job queue. A monitor on the falling
//   clock edge pops the queue on each launch. It then follows the job at
//   job level: launch width, modes, pause forwarding, retirement count, and
//   the watchdog (done after N unpaused cycles, or fault after TIMEOUT_CYC
//   unpaused cycles if done never arrives). A small machine model drives
//   wm_done.
module tb_wash_job_scheduler;
    localparam int DEPTH       = 4;
    localparam int LAUNCH_CYC  = 2;
    localparam int TIMEOUT_CYC = 400;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       job_valid = 1'b0;
    logic       job_double = 1'b0;
    logic       job_dry = 1'b0;
    logic       flush = 1'b0;
    logic       pause_req = 1'b0;
    logic       wm_done = 1'b0;
    logic       job_ready, wm_start, wm_double_wash, wm_dry_wash, wm_time_pause;
    logic       busy, fault;
    logic [2:0] queue_level;
    logic [7:0] jobs_done;

    wash_job_scheduler #(
        .DEPTH(DEPTH), .LAUNCH_CYC(LAUNCH_CYC), .TIMEOUT_CYC(TIMEOUT_CYC), .TMR_W(9)
    ) dut (
        .clk(clk), .rst(rst), .job_valid(job_valid), .job_double(job_double),
        .job_dry(job_dry), .job_ready(job_ready), .flush(flush), .pause_req(pause_req),
        .wm_start(wm_start), .wm_double_wash(wm_double_wash), .wm_dry_wash(wm_dry_wash),
        .wm_time_pause(wm_time_pause), .wm_done(wm_done), .busy(busy),
        .queue_level(queue_level), .jobs_done(jobs_done), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit dbl;
        bit dry;
        int after;   // unpaused run cycles until done; 0 = never
    } job_t;

    job_t exp_q[$];
    job_t cur;
    int   checks = 0;
    int   failures = 0;
    int   accepted = 0;

    // Values the stimulus wants on the inputs for the next edge.
    bit d_rst = 1'b1, d_flush, d_pause, d_valid, d_double, d_dry;
    int d_after;

    // Monitor / reference state.
    bit fault_exp, busy_exp, in_run, prev_start, was_run, tp_exp;
    int exp_done, start_hi, run_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: settle model effects of the edge just passed,
    // then drive the next inputs and check readiness.
    task automatic tick();
        bit ready_exp;
        @(negedge clk);
        #1;
        if (flush || rst) exp_q.delete();
        chk("queue_level", queue_level, exp_q.size());
        rst        = d_rst;
        flush      = d_flush;
        pause_req  = d_pause;
        job_valid  = d_valid;
        job_double = d_double;
        job_dry    = d_dry;
        ready_exp  = (exp_q.size() < DEPTH) && !d_flush && !fault_exp;
        #1;
        chk("job_ready", job_ready, ready_exp);
        if (d_valid && ready_exp) begin
            exp_q.push_back('{dbl: d_double, dry: d_dry, after: d_after});
            accepted++;
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic push_job(input bit dbl, input bit dry, input int after);
        d_valid = 1'b1; d_double = dbl; d_dry = dry; d_after = after;
        tick();
        d_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy !== 1'b0 && n < limit) begin
            tick();
            n++;
        end
        chk("wait_idle_in_time", busy, 0);
    endtask

    // Machine model: done rises on its Nth unpaused run cycle, drops on start.
    bit m_run, m_prev_start;
    int m_cnt, m_after;
    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            m_run = 1'b0; m_prev_start = 1'b0; wm_done = 1'b0;
        end else begin
            if (wm_start) begin
                wm_done = 1'b0; m_run = 1'b0;
            end else if (m_prev_start) begin
                m_run = 1'b1; m_cnt = 0; m_after = cur.after;
            end
            m_prev_start = wm_start;
            if (m_run && !pause_req) begin
                m_cnt++;
                if (m_cnt == m_after) begin
                    wm_done = 1'b1; m_run = 1'b0;
                end
            end
        end
    end

    // Monitor: outputs are sampled mid-cycle, inputs still hold the values
    // that the last edge consumed.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_job_ready", job_ready, 1);
                chk("rst_queue_level", queue_level, 0);
                chk("rst_busy", busy, 0);
                chk("rst_fault", fault, 0);
                chk("rst_jobs_done", jobs_done, 0);
                chk("rst_wm_outputs", {wm_start, wm_double_wash, wm_dry_wash, wm_time_pause}, 0);
                fault_exp = 0; busy_exp = 0; in_run = 0; prev_start = 0;
                exp_done = 0; start_hi = 0;
            end else begin
                was_run = in_run;
                tp_exp  = 0;
                if (wm_start && !prev_start) begin
                    chk("launch_has_job", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) cur = exp_q.pop_front();
                    busy_exp = 1;
                    start_hi = 0;
                end
                if (wm_start) start_hi++;
                if (!wm_start && prev_start) begin
                    chk("start_width", start_hi, LAUNCH_CYC);
                    in_run  = 1;
                    run_cnt = 0;
                end else if (was_run) begin
                    if (!pause_req) run_cnt++;
                    if (cur.after != 0 && run_cnt == cur.after) begin
                        if (exp_done < 255) exp_done++;
                        busy_exp = 0; in_run = 0;
                    end else if (run_cnt == TIMEOUT_CYC) begin
                        fault_exp = 1; busy_exp = 0; in_run = 0;
                    end else begin
                        tp_exp = pause_req;
                    end
                end
                prev_start = wm_start;
                chk("busy", busy, busy_exp);
                chk("fault", fault, fault_exp);
                chk("jobs_done", jobs_done, exp_done);
                chk("time_pause", wm_time_pause, tp_exp);
                chk("mode_double", wm_double_wash, busy_exp ? cur.dbl : 1'b0);
                chk("mode_dry", wm_dry_wash, busy_exp ? cur.dry : 1'b0);
                if (fault_exp) chk("start_in_fault", wm_start, 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int base, n;
        // T1: reset held for two edges.
        tick();
        d_rst = 0;
        run(2);

        // T2: double wash, done 290 cycles after start falls.
        push_job(1, 0, 290);
        tick();
        chk("t2_no_start_on_accept_edge", wm_start, 0);
        tick();
        chk("t2_start_next_edge", wm_start, 1);
        chk("t2_double_at_launch", wm_double_wash, 1);
        wait_idle(400);
        chk("t2_jobs_done", jobs_done, 1);

        // T4: 100 paused cycles inside a 380-cycle job; no watchdog fault.
        push_job(0, 1, 380);
        run(40);
        d_pause = 1;
        run(100);
        d_pause = 0;
        wait_idle(600);
        chk("t4_no_fault", fault, 0);
        chk("t4_jobs_done", jobs_done, 2);

        // Done on the very cycle the watchdog would expire: done wins.
        push_job(1, 1, TIMEOUT_CYC);
        run(3);
        wait_idle(600);
        chk("done_at_timeout_no_fault", fault, 0);
        chk("done_at_timeout_jobs_done", jobs_done, 3);

        // T6: reset mid-run with two jobs queued.
        push_job(0, 0, 0);
        run(20);
        push_job(1, 0, 50);
        push_job(0, 1, 50);
        tick();
        chk("t6_queued_before_rst", queue_level, 2);
        chk("t6_busy_before_rst", busy, 1);
        d_rst = 1;
        tick();
        d_rst = 0;
        tick();
        chk("t6_queue_cleared", queue_level, 0);
        chk("t6_jobs_done_cleared", jobs_done, 0);
        chk("t6_outputs_cleared", {wm_start, wm_double_wash, wm_dry_wash, wm_time_pause, busy}, 0);

        // T3: never-completing job, offer a job every cycle.
        base = accepted;
        d_valid = 1; d_double = 0; d_dry = 1; d_after = 0;
        run(8);
        d_valid = 0;
        tick();
        chk("t3_accepted", accepted - base, 5);
        chk("t3_level_full", queue_level, DEPTH);
        chk("t3_not_ready", job_ready, 0);
        d_flush = 1;
        tick();
        d_flush = 0;
        tick();
        chk("t3_flush_level", queue_level, 0);
        chk("t3_flush_busy", busy, 1);

        // T5: watchdog expiry with jobs queued.
        push_job(1, 1, 0);
        push_job(0, 0, 0);
        n = 0;
        while (fault !== 1'b1 && n < 500) begin
            tick();
            n++;
        end
        run(5);
        chk("t5_fault", fault, 1);
        chk("t5_start_low", wm_start, 0);
        chk("t5_queue_frozen", queue_level, 2);
        chk("t5_not_ready", job_ready, 0);
        chk("t5_busy_low", busy, 0);
        d_rst = 1;
        tick();
        d_rst = 0;
        tick();

        // Random traffic: modes, completion times, pause bursts, flushes.
        for (int i = 0; i < 3000; i++) begin
            d_valid  = ($urandom_range(0, 99) < 40);
            d_double = $urandom_range(0, 1);
            d_dry    = $urandom_range(0, 1);
            d_after  = $urandom_range(10, 150);
            if ($urandom_range(0, 99) < 4) d_pause = ~d_pause;
            d_flush  = ($urandom_range(0, 99) < 1);
            tick();
        end
        d_flush = 0;
        d_pause = 0;

        // Short jobs back to back until the completion counter saturates.
        n = 0;
        while (jobs_done !== 8'd255 && n < 6000) begin
            d_valid  = ($urandom_range(0, 99) < 80);
            d_double = $urandom_range(0, 1);
            d_dry    = $urandom_range(0, 1);
            d_after  = $urandom_range(1, 4);
            d_pause  = ($urandom_range(0, 99) < 5);
            tick();
            n++;
        end
        run(100);
        d_valid = 0;
        d_pause = 0;
        run(20);
        chk("jobs_done_saturated", jobs_done, 255);
        chk("no_fault_after_traffic", fault, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
